// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages, DM has priority.
// Define ARB_TIMEOUT_EN to abort accesses unacknowledged for TIMEOUT cycles and pulse bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall_f,
  output logic                stall_m,
  output logic                bus_err
);
  typedef enum logic [1:0] {IDLE, GNT_DM, GNT_IF, RESP} state_t;
  state_t              state_q;
  logic                sel_dm_q, kill_q, if_ready_q, dm_ready_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic [DATA_W/8-1:0] mem_wmask_q;
  logic                tmo;
`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        bus_err_q;
  assign tmo     = cnt_q == 16'(TIMEOUT - 1);
  assign bus_err = bus_err_q;
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  // A flush arriving during the response cycle still cancels the fetch.
  assign if_ready  = if_ready_q & ~if_kill;
  assign stall_f   = if_req & ~if_ready & ~if_kill;
  assign stall_m   = dm_req & ~dm_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_dm_q    <= 1'b0;
      kill_q      <= 1'b0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus_err_q  <= 1'b0;
      cnt_q      <= cnt_q + 16'd1;
`endif
      case (state_q)
        IDLE: begin
          if (dm_req || (if_req && !if_kill)) begin
            state_q     <= dm_req ? GNT_DM : GNT_IF;
            sel_dm_q    <= dm_req;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_req & dm_we;
            mem_addr_q  <= dm_req ? dm_addr : if_addr;
            mem_wdata_q <= dm_wdata;
            mem_wmask_q <= dm_req ? dm_wmask : '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        GNT_DM, GNT_IF: begin
          if (state_q == GNT_IF && if_kill) kill_q <= 1'b1;
          if (mem_ack || tmo) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus_err_q <= ~mem_ack;
`endif
            // Timed-out accesses return zero; completed stores leave dm_rdata alone.
            if (sel_dm_q) begin
              dm_ready_q <= 1'b1;
              if (!mem_we_q || !mem_ack) dm_rdata_q <= mem_ack ? mem_rdata : '0;
            end else if (!(kill_q || if_kill)) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          kill_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, wait states, kill, reset and timeout.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        if_req = 1'b0, if_kill = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0]  dm_wmask = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        if_ready, dm_ready, mem_req, mem_we, stall_f, stall_m, bus_err;
  int          checks = 0, errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_req, if_ready, dm_ready, bus_err, if_rdata, dm_rdata} !== '0) begin
      errors++; $display("FAIL reset outputs got %h exp 0", {mem_req, if_ready, dm_ready, bus_err, if_rdata, dm_rdata});
    end
    cyc(); reset_n = 1'b1; cyc();
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h100; #1;
    checks++;
    if ({stall_f, mem_req} !== 2'b10) begin errors++; $display("FAIL ifrd c0 stall_f/mem_req got %b exp 10", {stall_f, mem_req}); end
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h00500093; #1;
    checks++;
    if ({stall_f, mem_req, mem_we, mem_wmask, mem_addr} !== {3'b110, 4'h0, 32'h100}) begin
      errors++; $display("FAIL ifrd c1 got %h exp %h", {stall_f, mem_req, mem_we, mem_wmask, mem_addr}, {3'b110, 4'h0, 32'h100});
    end
    cyc(); mem_ack = 1'b0;
    checks++;
    if ({if_ready, mem_req, stall_f, if_rdata} !== {3'b100, 32'h00500093}) begin
      errors++; $display("FAIL ifrd c2 got %h exp %h", {if_ready, mem_req, stall_f, if_rdata}, {3'b100, 32'h00500093});
    end
    if_req = 1'b0; cyc();
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL ifrd c3 if_ready got %b exp 0", if_ready); end
  endtask

  task automatic test_priority();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_wmask = 4'hF;
    if_req = 1'b1; if_addr = 32'h104; #1;
    checks++;
    if ({stall_f, stall_m} !== 2'b11) begin errors++; $display("FAIL prio c0 stalls got %b exp 11", {stall_f, stall_m}); end
    cyc(); mem_ack = 1'b1; #1;
    checks++;
    if ({mem_req, mem_we, mem_wmask, mem_addr, mem_wdata} !== {2'b11, 4'hF, 32'h200, 32'hDEADBEEF}) begin
      errors++; $display("FAIL prio dm grant got %h exp %h", {mem_req, mem_we, mem_wmask, mem_addr, mem_wdata}, {2'b11, 4'hF, 32'h200, 32'hDEADBEEF});
    end
    cyc(); mem_ack = 1'b0;
    checks++;
    if ({dm_ready, stall_m, stall_f, if_ready, dm_rdata} !== {4'b1010, 32'h0}) begin
      errors++; $display("FAIL prio dm resp got %h exp %h", {dm_ready, stall_m, stall_f, if_ready, dm_rdata}, {4'b1010, 32'h0});
    end
    dm_req = 1'b0; dm_we = 1'b0; cyc();
    checks++;
    if ({mem_req, stall_f} !== 2'b01) begin errors++; $display("FAIL prio idle got %b exp 01", {mem_req, stall_f}); end
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h11111111; #1;
    checks++;
    if ({mem_req, mem_we, mem_wmask, mem_addr} !== {2'b10, 4'h0, 32'h104}) begin
      errors++; $display("FAIL prio if grant got %h exp %h", {mem_req, mem_we, mem_wmask, mem_addr}, {2'b10, 4'h0, 32'h104});
    end
    cyc(); mem_ack = 1'b0;
    checks++;
    if ({if_ready, if_rdata} !== {1'b1, 32'h11111111}) begin
      errors++; $display("FAIL prio if resp got %h exp %h", {if_ready, if_rdata}, {1'b1, 32'h11111111});
    end
    if_req = 1'b0; cyc();
  endtask

  task automatic test_wait_states();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_wdata = 32'h5555AAAA; dm_wmask = 4'h3;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      mem_ack = (c == 4); mem_rdata = (c == 4) ? 32'hCAFEF00D : 32'h12345678; #1;
      checks++;
      if ({mem_req, mem_we, dm_ready, mem_addr, mem_wdata, mem_wmask} !== {3'b100, 32'h300, 32'h5555AAAA, 4'h3}) begin
        errors++; $display("FAIL wait c%0d got %h exp %h", c, {mem_req, mem_we, dm_ready, mem_addr, mem_wdata, mem_wmask}, {3'b100, 32'h300, 32'h5555AAAA, 4'h3});
      end
    end
    cyc(); mem_ack = 1'b0;
    checks++;
    if ({dm_ready, mem_req, bus_err, dm_rdata} !== {3'b100, 32'hCAFEF00D}) begin
      errors++; $display("FAIL wait resp got %h exp %h", {dm_ready, mem_req, bus_err, dm_rdata}, {3'b100, 32'hCAFEF00D});
    end
    dm_req = 1'b0; cyc();
    checks++;
    if (dm_ready !== 1'b0) begin errors++; $display("FAIL wait after dm_ready got %b exp 0", dm_ready); end
  endtask

  task automatic test_store_hold();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h304; dm_wdata = 32'h0;
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h77777777;
    cyc(); mem_ack = 1'b0;
    checks++;
    if ({dm_ready, dm_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      errors++; $display("FAIL store hold got %h exp %h", {dm_ready, dm_rdata}, {1'b1, 32'hCAFEF00D});
    end
    dm_req = 1'b0; dm_we = 1'b0; cyc();
  endtask

  task automatic test_kill();
    if_req = 1'b1; if_addr = 32'h400;
    cyc(); if_kill = 1'b1; if_addr = 32'h500; #1;
    checks++;
    if ({mem_req, stall_f} !== 2'b10) begin errors++; $display("FAIL kill c1 got %b exp 10", {mem_req, stall_f}); end
    cyc(); if_kill = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h99999999;
    cyc(); mem_ack = 1'b0;
    checks++;
    if ({if_ready, mem_req, if_rdata} !== {2'b00, 32'h11111111}) begin
      errors++; $display("FAIL kill resp got %h exp %h", {if_ready, mem_req, if_rdata}, {2'b00, 32'h11111111});
    end
    cyc(); cyc(); mem_ack = 1'b1; mem_rdata = 32'h22222222; #1;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
      errors++; $display("FAIL kill regrant got %h exp %h", {mem_req, mem_addr}, {1'b1, 32'h500});
    end
    cyc(); mem_ack = 1'b0;
    checks++;
    if ({if_ready, if_rdata} !== {1'b1, 32'h22222222}) begin
      errors++; $display("FAIL kill refetch got %h exp %h", {if_ready, if_rdata}, {1'b1, 32'h22222222});
    end
    if_req = 1'b0; cyc();
  endtask

  task automatic test_reset_mid();
    dm_req = 1'b1; dm_addr = 32'h600;
    cyc(); #1;
    reset_n = 1'b0; #1;
    checks++;
    if ({mem_req, dm_ready, if_ready, dm_rdata, if_rdata} !== '0) begin
      errors++; $display("FAIL rstmid async got %h exp 0", {mem_req, dm_ready, if_ready, dm_rdata, if_rdata});
    end
    dm_req = 1'b0; #2; reset_n = 1'b1;
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h33333333;
    cyc(); mem_ack = 1'b0;
    cyc();
    checks++;
    if ({mem_req, dm_ready, dm_rdata} !== '0) begin
      errors++; $display("FAIL rstmid stray ack got %h exp 0", {mem_req, dm_ready, dm_rdata});
    end
    if_req = 1'b1; if_addr = 32'h700;
    cyc();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin
      errors++; $display("FAIL rstmid idle grant got %h exp %h", {mem_req, mem_addr}, {1'b1, 32'h700});
    end
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0; if_req = 1'b0; cyc();
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800;
    cyc(); mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    cyc(); mem_ack = 1'b0;
    dm_req = 1'b0; cyc();
    dm_req = 1'b1; dm_addr = 32'h804;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++;
      if ({mem_req, dm_ready, bus_err} !== 3'b100) begin
        errors++; $display("FAIL tmo c%0d got %b exp 100", c, {mem_req, dm_ready, bus_err});
      end
    end
    cyc();
    checks++;
    if ({mem_req, dm_ready, bus_err, dm_rdata} !== {3'b011, 32'h0}) begin
      errors++; $display("FAIL tmo resp got %h exp %h", {mem_req, dm_ready, bus_err, dm_rdata}, {3'b011, 32'h0});
    end
    dm_req = 1'b0; cyc();
    checks++;
    if ({dm_ready, bus_err} !== 2'b00) begin errors++; $display("FAIL tmo after got %b exp 00", {dm_ready, bus_err}); end
`else
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err tied got %b exp 0", bus_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_wait_states();
    test_store_hold();
    test_kill();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (IF) and the memory stage (DM).
- Fixed priority: DM wins over IF, because DM is the older instruction.
- Sequences the memory's req/ack handshake and reports wait-state stalls to the hazard logic.
- stall_f and stall_m are ORed by the top level into the existing StallF/StallD and stall-M paths.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, cycles without mem_ack before a granted access is aborted (used only with ARB_TIMEOUT_EN); range 1..65535.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ready or if_kill.
- if_addr  in  ADDR_W  fetch address.
- if_kill  in  1  fetch flushed by a taken branch (PCSrcE).
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready.
- if_ready  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_wmask  in  DATA_W/8  byte enables.
- dm_rdata  out  DATA_W  load data; valid while dm_ready.
- dm_ready  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- stall_f  out  1  = if_req & ~if_ready & ~if_kill (combinational).
- stall_m  out  1  = dm_req & ~dm_ready (combinational).
- bus_err  out  1  one-cycle timeout pulse.

Behaviour:
- FSM states: IDLE, GNT_DM, GNT_IF, RESP. Reset enters IDLE.
- Reset values: all registered outputs 0, rdata registers 0, kill flag 0, counter 0.
- IDLE:
  - dm_req → GNT_DM.
  - else if_req & ~if_kill → GNT_IF.
  - else stay.
  - On the transition, latch addr/we/wdata/wmask into mem_* regs and set mem_req=1.
  - IF grants force mem_we=0 and mem_wmask=0.
- GNT_x:
  - mem_* outputs held stable.
  - mem_ack=1 → capture mem_rdata into the selected rdata register, clear mem_req, go to RESP.
- RESP: exactly one cycle.
  - Pulse the granted ready signal; ready is registered.
  - No arbitration in this cycle; return to IDLE.
  - The requester drops or changes its req after seeing ready.
- Minimum latency: req at cycle 0 → mem_req at cycle 1 → ack at cycle 1 → ready at cycle 2.
- Throughput: one access per 3 cycles minimum.
- Simultaneous dm_req and if_req in IDLE → DM granted; IF waits and stall_f stays high.
- if_kill:
  - In IDLE: no grant is made to IF that cycle.
  - During GNT_IF: sets a kill flag. The access completes normally on the memory side, but if_ready is suppressed in RESP and if_rdata is not updated.
  - In RESP(IF): if_ready forced to 0.
  - Kill flag clears on entry to IDLE.
- dm_rdata is updated for loads only; for stores it holds its old value, and dm_ready still pulses.
- mem_ack outside GNT_x is ignored.
- reset_n low mid-access:
  - Immediately IDLE; mem_req=0 asynchronously; the outstanding ack is ignored.
  - The memory model must tolerate an abandoned request.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to GNT_x and increments each cycle without ack.
  - When it reaches TIMEOUT: clear mem_req, go to RESP.
  - In RESP: pulse ready with rdata=0 (the IF pulse is still subject to if_kill) and pulse bus_err=1 for one cycle.
  - An ack in the same cycle as the timeout wins: normal completion, no bus_err.
- Undefined:
  - No counter logic; bus_err tied 0; waits for ack indefinitely.

Test Plan:
- IF-only read, addr 0x100, mem_ack on the first cycle of mem_req with mem_rdata 0x00500093 → mem_req high for exactly 1 cycle, if_ready at cycle 2 with if_rdata 0x00500093, stall_f high in cycles 0-1.
- dm_req store (0x200, 0xDEADBEEF, mask 0xF) and if_req in the same cycle → DM granted first with mem_we=1; IF granted after DM's RESP; mem_addr sequence 0x200 then IF address.
- Load with 3 wait states (ack on the 4th cycle of mem_req) → mem_addr/mem_wdata stable for all 4 cycles, dm_ready exactly 1 cycle later, dm_rdata = mem_rdata at ack.
- if_kill pulsed during GNT_IF → memory access completes, if_ready never asserts, if_rdata unchanged, next IF grant uses the new if_addr.
- reset_n low during GNT_DM → mem_req 0 immediately, state IDLE, ready outputs 0; an ack after release produces no ready.
- With ARB_TIMEOUT_EN and TIMEOUT=4, no ack → mem_req drops after 4 cycles, bus_err and dm_ready pulse together, dm_rdata=0.
